// File: rtl/csr_issue_sequencer_if.sv
// Shared micro-op/branch types and the issue-side bus of csr_issue_sequencer.
// OUT_stallCycles exists only when CSRSEQ_STALL_CNT_EN is defined.
package csr_seq_pkg;
    localparam int SQN_W = 6;

    typedef enum logic [2:0] {
        CSR_R   = 3'd0,
        CSR_RW  = 3'd1,
        CSR_RS  = 3'd2,
        CSR_RC  = 3'd3,
        CSR_RWI = 3'd4,
        CSR_RSI = 3'd5,
        CSR_RCI = 3'd6
    } csr_op_e;

    typedef struct packed {
        logic [SQN_W-1:0] sqN;
        csr_op_e          opcode;
        logic [31:0]      imm;
        logic [31:0]      srcA;
        logic [31:0]      pc;
        logic [4:0]       nmDst;
        logic [6:0]       tagDst;
        logic             compressed;
        logic             valid;
    } EX_UOp;

    typedef struct packed {
        logic             taken;
        logic [SQN_W-1:0] sqN;
    } BranchProv;
endpackage

interface csr_issue_sequencer_if;
    import csr_seq_pkg::*;

    EX_UOp            IN_uop;
    logic             OUT_ready;
    BranchProv        IN_branch;
    logic [SQN_W-1:0] IN_commitSqN;
    EX_UOp            OUT_uop;
    logic             OUT_busy;
`ifdef CSRSEQ_STALL_CNT_EN
    logic [31:0]      OUT_stallCycles;

    modport master (
        output IN_uop, IN_branch, IN_commitSqN,
        input  OUT_ready, OUT_uop, OUT_busy, OUT_stallCycles
    );
    modport slave (
        input  IN_uop, IN_branch, IN_commitSqN,
        output OUT_ready, OUT_uop, OUT_busy, OUT_stallCycles
    );
`else
    modport master (
        output IN_uop, IN_branch, IN_commitSqN,
        input  OUT_ready, OUT_uop, OUT_busy
    );
    modport slave (
        input  IN_uop, IN_branch, IN_commitSqN,
        output OUT_ready, OUT_uop, OUT_busy
    );
`endif
endinterface

// File: rtl/csr_issue_sequencer.sv
// In-order CSR micro-op queue; writes are released only when oldest and serialized until commit.
// Optional stall-cycle counter enabled by CSRSEQ_STALL_CNT_EN.
module csr_issue_sequencer
    import csr_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SQN_W = csr_seq_pkg::SQN_W
) (
    input logic                  clk,
    input logic                  rst,
    csr_issue_sequencer_if.slave bus_io
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE        = 1'b0,
        WAIT_RETIRE = 1'b1
    } state_e;

    // a is strictly younger than b: signed difference at SQN_W bits is positive
    function automatic logic sqn_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] diff;
        diff = a - b;
        return (diff != {SQN_W{1'b0}}) && !diff[SQN_W-1];
    endfunction

    EX_UOp            mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q;
    logic [SQN_W-1:0] last_sqn_q;
    EX_UOp            out_uop_q;
    logic             ready_q;
    logic             busy_q;

    logic [CNT_W-1:0] keep_cnt_s;
    logic [PTR_W-1:0] idx_s;
    logic [PTR_W-1:0] tail_flush_s;
    EX_UOp            head_uop_s;
    EX_UOp            issue_uop_s;
    logic             issue_s;
    logic             drop_s;
    logic             enq_s;

    // Flush truncation, then issue from the surviving head, then enqueue behind the new tail
    always_comb begin
        keep_cnt_s = count_q;
        idx_s      = head_q;
        // Descending scan so the oldest younger-than-branch entry sets the survivor count
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx_s      = head_q + PTR_W'(i);
            keep_cnt_s = (bus_io.IN_branch.taken && (CNT_W'(i) < count_q) &&
                          sqn_younger(mem_q[idx_s].sqN, bus_io.IN_branch.sqN)) ? CNT_W'(i) : keep_cnt_s;
        end

        tail_flush_s = (keep_cnt_s != count_q) ? (head_q + keep_cnt_s[PTR_W-1:0]) : tail_q;
        head_uop_s   = mem_q[head_q];

        issue_s = (state_q == IDLE) && (keep_cnt_s != {CNT_W{1'b0}}) &&
                  ((head_uop_s.opcode == CSR_R) || (head_uop_s.sqN == bus_io.IN_commitSqN));

        if (issue_s) begin
            issue_uop_s       = head_uop_s;
            issue_uop_s.valid = 1'b1;
        end else begin
            issue_uop_s = '0;
        end

        drop_s  = bus_io.IN_branch.taken && sqn_younger(bus_io.IN_uop.sqN, bus_io.IN_branch.sqN);
        enq_s   = bus_io.IN_uop.valid && (count_q != FULL_CNT) && !drop_s;

        count_d = keep_cnt_s - CNT_W'(issue_s) + CNT_W'(enq_s);
        head_d  = head_q + PTR_W'(issue_s);
        tail_d  = tail_flush_s + PTR_W'(enq_s);
    end

    // Queue storage; contents beyond count are never observed, so no reset is needed
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_q[tail_flush_s] <= bus_io.IN_uop;
        end else begin
            mem_q[tail_flush_s] <= mem_q[tail_flush_s];
        end
    end

    // Pointers, count, release FSM and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= {PTR_W{1'b0}};
            tail_q     <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            state_q    <= IDLE;
            last_sqn_q <= {SQN_W{1'b0}};
            out_uop_q  <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            out_uop_q <= issue_uop_s;
            ready_q   <= (count_d != FULL_CNT);
            case (state_q)
                IDLE: begin
                    if (issue_s && (head_uop_s.opcode != CSR_R)) begin
                        state_q    <= WAIT_RETIRE;
                        last_sqn_q <= head_uop_s.sqN;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q    <= IDLE;
                        last_sqn_q <= last_sqn_q;
                        busy_q     <= (count_d != {CNT_W{1'b0}});
                    end
                end
                WAIT_RETIRE: begin
                    last_sqn_q <= last_sqn_q;
                    // The latched write was oldest when released, so no flush can cancel it
                    if (sqn_younger(bus_io.IN_commitSqN, last_sqn_q)) begin
                        state_q <= IDLE;
                        busy_q  <= (count_d != {CNT_W{1'b0}});
                    end else begin
                        state_q <= WAIT_RETIRE;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    last_sqn_q <= last_sqn_q;
                    busy_q     <= (count_d != {CNT_W{1'b0}});
                end
            endcase
        end
    end

    assign bus_io.OUT_uop   = out_uop_q;
    assign bus_io.OUT_ready = ready_q;
    assign bus_io.OUT_busy  = busy_q;

`ifdef CSRSEQ_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles with queued work but no release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else if ((count_q != {CNT_W{1'b0}}) && !issue_s && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end else begin
            stall_q <= stall_q;
        end
    end

    assign bus_io.OUT_stallCycles = stall_q;
`endif
endmodule

// File: tb/tb_csr_issue_sequencer.sv
// Scoreboard bench for csr_issue_sequencer: expected micro-ops are queued when driven
// and matched in order against OUT_uop; stall checks follow CSRSEQ_STALL_CNT_EN.
`timescale 1ns/1ps
module tb_csr_issue_sequencer;
    import csr_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_issue_sequencer_if bus();

    csr_issue_sequencer #(.DEPTH(4), .SQN_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int    tests_run    = 0;
    int    tests_failed = 0;
    int    issue_cnt    = 0;
    EX_UOp exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_uop(input logic [5:0] sqn, input csr_op_e op, input bit expect_issue);
        EX_UOp u;
        u            = '0;
        u.sqN        = sqn;
        u.opcode     = op;
        u.imm        = $urandom;
        u.srcA       = $urandom;
        u.pc         = 32'h0000_1000 + {24'd0, sqn, 2'b00};
        u.nmDst      = 5'(sqn);
        u.tagDst     = 7'(sqn);
        u.compressed = sqn[0];
        u.valid      = 1'b1;
        bus.IN_uop   = u;
        if (expect_issue) exp_q.push_back(u);
        tick();
        bus.IN_uop.valid = 1'b0;
    endtask

    // Scoreboard: every release must match the oldest outstanding expectation
    always @(negedge clk) begin
        EX_UOp e;
        if (!rst && bus.OUT_uop.valid) begin
            issue_cnt++;
            check_eq("issue_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("issue_uop",
                         {23'd0, bus.OUT_uop.imm[15:0], bus.OUT_uop.pc[15:0], bus.OUT_uop.sqN, bus.OUT_uop.opcode},
                         {23'd0, e.imm[15:0], e.pc[15:0], e.sqN, e.opcode});
            end
        end
    end

    initial begin
        int base;
        rst              = 1'b1;
        bus.IN_uop       = '0;
        bus.IN_branch    = '0;
        bus.IN_commitSqN = 6'd0;
        repeat (2) tick();
        check_eq("rst_valid", bus.OUT_uop.valid, 1'b0);
        check_eq("rst_ready", bus.OUT_ready, 1'b1);
        check_eq("rst_busy", bus.OUT_busy, 1'b0);
`ifdef CSRSEQ_STALL_CNT_EN
        check_eq("rst_stall", bus.OUT_stallCycles, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Read latency
        drive_uop(6'd3, CSR_R, 1'b1);
        check_eq("rd_e0_valid", bus.OUT_uop.valid, 1'b0);
        check_eq("rd_e0_busy", bus.OUT_busy, 1'b1);
        tick();
        check_eq("rd_e1_valid", bus.OUT_uop.valid, 1'b1);
        check_eq("rd_e1_sqn", bus.OUT_uop.sqN, 6'd3);
        tick();
        check_eq("rd_e2_valid", bus.OUT_uop.valid, 1'b0);
        check_eq("rd_e2_busy", bus.OUT_busy, 1'b0);

        // Write ordering
        bus.IN_commitSqN = 6'd3;
        drive_uop(6'd5, CSR_RW, 1'b1);
        drive_uop(6'd6, CSR_R, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("wr_hold", bus.OUT_uop.valid, 1'b0);
        end
        bus.IN_commitSqN = 6'd5;
        tick();
        check_eq("wr_rel_valid", bus.OUT_uop.valid, 1'b1);
        check_eq("wr_rel_sqn", bus.OUT_uop.sqN, 6'd5);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("wr_wait_hold", bus.OUT_uop.valid, 1'b0);
        end
        bus.IN_commitSqN = 6'd6;
        tick();
        check_eq("wr_exit_cycle", bus.OUT_uop.valid, 1'b0);
        tick();
        check_eq("rd_after_wr_valid", bus.OUT_uop.valid, 1'b1);
        check_eq("rd_after_wr_sqn", bus.OUT_uop.sqN, 6'd6);
        tick();
        check_eq("wr_done_busy", bus.OUT_busy, 1'b0);

        // Full queue
        bus.IN_commitSqN = 6'd10;
        for (int k = 0; k < 4; k++) drive_uop(6'(20 + k), CSR_RS, 1'b1);
        check_eq("full_ready", bus.OUT_ready, 1'b0);
        drive_uop(6'd24, CSR_RC, 1'b0);
        check_eq("full_ready_hold", bus.OUT_ready, 1'b0);
        base = issue_cnt;
        for (int k = 0; k < 4; k++) begin
            bus.IN_commitSqN = 6'(20 + k);
            repeat (3) tick();
        end
        bus.IN_commitSqN = 6'd24;
        repeat (4) tick();
        check_eq("full_issue_cnt", 64'(issue_cnt - base), 64'd4);
        check_eq("full_busy", bus.OUT_busy, 1'b0);
        check_eq("full_ready_after", bus.OUT_ready, 1'b1);

        // Flush: blocked head 10, younger 11/12 and same-cycle 13 removed
        bus.IN_commitSqN = 6'd9;
        drive_uop(6'd10, CSR_RW, 1'b1);
        drive_uop(6'd11, CSR_R, 1'b0);
        drive_uop(6'd12, CSR_R, 1'b0);
        bus.IN_branch.taken = 1'b1;
        bus.IN_branch.sqN   = 6'd10;
        drive_uop(6'd13, CSR_R, 1'b0);
        bus.IN_branch.taken = 1'b0;
        check_eq("flush_busy", bus.OUT_busy, 1'b1);
        check_eq("flush_ready", bus.OUT_ready, 1'b1);
        drive_uop(6'd14, CSR_R, 1'b1);
        drive_uop(6'd15, CSR_R, 1'b1);
        check_eq("flush_cnt3_ready", bus.OUT_ready, 1'b1);
        drive_uop(6'd16, CSR_R, 1'b1);
        check_eq("flush_cnt4_ready", bus.OUT_ready, 1'b0);
        bus.IN_commitSqN = 6'd10;
        repeat (2) tick();
        bus.IN_commitSqN = 6'd17;
        repeat (6) tick();
        check_eq("flush_busy_end", bus.OUT_busy, 1'b0);
        check_eq("flush_drained", 64'(exp_q.size()), 64'd0);

        // Sequence-number wrap
        bus.IN_commitSqN = 6'd62;
        drive_uop(6'd63, CSR_RW, 1'b1);
        drive_uop(6'd0, CSR_RWI, 1'b1);
        bus.IN_commitSqN = 6'd63;
        tick();
        check_eq("wrap_63_sqn", {bus.OUT_uop.valid, bus.OUT_uop.sqN}, {1'b1, 6'd63});
        bus.IN_commitSqN = 6'd0;
        tick();
        check_eq("wrap_exit_cycle", bus.OUT_uop.valid, 1'b0);
        tick();
        check_eq("wrap_0_sqn", {bus.OUT_uop.valid, bus.OUT_uop.sqN}, {1'b1, 6'd0});
        bus.IN_commitSqN = 6'd1;
        repeat (3) tick();
        check_eq("wrap_busy", bus.OUT_busy, 1'b0);

        // Asynchronous reset in WAIT_RETIRE with three queued writes
        bus.IN_commitSqN = 6'd30;
        drive_uop(6'd31, CSR_RW, 1'b1);
        drive_uop(6'd32, CSR_RW, 1'b0);
        drive_uop(6'd33, CSR_RS, 1'b0);
        drive_uop(6'd34, CSR_RC, 1'b0);
        bus.IN_commitSqN = 6'd31;
        tick();
        check_eq("ar_rel_sqn", {bus.OUT_uop.valid, bus.OUT_uop.sqN}, {1'b1, 6'd31});
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_valid", bus.OUT_uop.valid, 1'b0);
        check_eq("ar_ready", bus.OUT_ready, 1'b1);
        check_eq("ar_busy", bus.OUT_busy, 1'b0);
`ifdef CSRSEQ_STALL_CNT_EN
        check_eq("ar_stall", bus.OUT_stallCycles, 32'd0);
`endif
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.IN_commitSqN = 6'(32 + k);
            repeat (3) tick();
        end
        check_eq("ar_busy_after", bus.OUT_busy, 1'b0);

        // Blocked write accumulates stall cycles
        bus.IN_commitSqN = 6'd50;
        drive_uop(6'd51, CSR_RW, 1'b1);
        repeat (3) tick();
`ifdef CSRSEQ_STALL_CNT_EN
        check_eq("stall_cnt", bus.OUT_stallCycles, 32'd3);
`endif
        check_eq("stall_busy", bus.OUT_busy, 1'b1);
        bus.IN_commitSqN = 6'd51;
        repeat (2) tick();
        bus.IN_commitSqN = 6'd52;
        repeat (3) tick();
        check_eq("final_busy", bus.OUT_busy, 1'b0);
        check_eq("final_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
